// File: rtl/decode_ctrl_if.sv
// Decode-stage bus: instruction in D, flush request from E, and the
// ID/EX control word, hazard stalls and illegal-instruction status.
interface decode_ctrl_if #(
    parameter int CNT_W = 8
);
    logic [31:0]      InstrD;
    logic             ValidD;
    logic             FlushE;
    logic [2:0]       ImmSrcD;
    logic             StallF;
    logic             StallD;
    logic             ValidE;
    logic             RegWriteE;
    logic [1:0]       ResultSrcE;
    logic             MemWriteE;
    logic             BranchE;
    logic             JumpE;
    logic             JalrE;
    logic             ALUSrcAE;
    logic             ALUSrcBE;
    logic [3:0]       ALUControlE;
    logic [4:0]       RdE;
    logic             IllegalE;
    logic [CNT_W-1:0] IllegalCnt;

    // Pipeline side: supplies the instruction, observes the control word
    modport master (
        output InstrD, ValidD, FlushE,
        input  ImmSrcD, StallF, StallD, ValidE, RegWriteE, ResultSrcE,
               MemWriteE, BranchE, JumpE, JalrE, ALUSrcAE, ALUSrcBE,
               ALUControlE, RdE, IllegalE, IllegalCnt
    );

    // Controller side
    modport slave (
        input  InstrD, ValidD, FlushE,
        output ImmSrcD, StallF, StallD, ValidE, RegWriteE, ResultSrcE,
               MemWriteE, BranchE, JumpE, JalrE, ALUSrcAE, ALUSrcBE,
               ALUControlE, RdE, IllegalE, IllegalCnt
    );
endinterface

// File: rtl/decode_ctrl.sv
// RV32I decode-stage controller: decodes the D instruction into the
// immediate select and the D->E control word, holds the ID/EX control
// register, stalls F/D on load-use, bubbles on flush and counts illegals.
module decode_ctrl #(
    parameter int CNT_W = 8
) (
    input logic          clk,
    input logic          rst_n,
    decode_ctrl_if.slave bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [3:0] alu_ctrl;
        logic [4:0] rd;
    } ctrl_t;

    // ALU op from funct3; alt_sub/alt_sra carry funct7[5] where it applies
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3,
                                               input logic alt_sub,
                                               input logic alt_sra);
        case (f3)
            3'b000:  return alt_sub ? 4'h1 : 4'h0;
            3'b001:  return 4'h7;
            3'b010:  return 4'h5;
            3'b011:  return 4'h6;
            3'b100:  return 4'h4;
            3'b101:  return alt_sra ? 4'h9 : 4'h8;
            3'b110:  return 4'h3;
            default: return 4'h2;
        endcase
    endfunction

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             f7b5;
    logic [4:0]       rd_f, rs1, rs2;
    ctrl_t            dec_p0;
    logic [2:0]       imm_src;
    logic             use_rs1, use_rs2, illegal;
    ctrl_t            ctrl_p1;
    logic             illegal_p1;
    logic [CNT_W-1:0] ill_cnt;
    logic             hazard;

    assign opcode = bus.InstrD[6:0];
    assign rd_f   = bus.InstrD[11:7];
    assign funct3 = bus.InstrD[14:12];
    assign rs1    = bus.InstrD[19:15];
    assign rs2    = bus.InstrD[24:20];
    assign f7b5   = bus.InstrD[30];

    // Opcode decode into the E control word, immediate select and register usage
    always_comb begin
        dec_p0       = '0;
        dec_p0.valid = 1'b1;
        imm_src      = 3'b000;
        use_rs1      = 1'b0;
        use_rs2      = 1'b0;
        illegal      = 1'b0;
        case (opcode)
            OP_R: begin
                dec_p0.reg_write = 1'b1;
                dec_p0.alu_ctrl  = alu_from_f3(funct3, f7b5, f7b5);
                use_rs1          = 1'b1;
                use_rs2          = 1'b1;
            end
            OP_I: begin
                dec_p0.reg_write = 1'b1;
                dec_p0.alu_src_b = 1'b1;
                dec_p0.alu_ctrl  = alu_from_f3(funct3, 1'b0, f7b5);
                use_rs1          = 1'b1;
            end
            OP_LOAD: begin
                dec_p0.reg_write  = 1'b1;
                dec_p0.result_src = 2'b01;
                dec_p0.alu_src_b  = 1'b1;
                use_rs1           = 1'b1;
            end
            OP_STORE: begin
                dec_p0.mem_write = 1'b1;
                dec_p0.alu_src_b = 1'b1;
                imm_src          = 3'b001;
                use_rs1          = 1'b1;
                use_rs2          = 1'b1;
            end
            OP_BRANCH: begin
                dec_p0.branch   = 1'b1;
                dec_p0.alu_ctrl = 4'h1;
                imm_src         = 3'b010;
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
            end
            OP_JAL: begin
                dec_p0.reg_write  = 1'b1;
                dec_p0.result_src = 2'b10;
                dec_p0.jump       = 1'b1;
                imm_src           = 3'b011;
            end
            OP_JALR: begin
                dec_p0.reg_write  = 1'b1;
                dec_p0.result_src = 2'b10;
                dec_p0.jump       = 1'b1;
                dec_p0.jalr       = 1'b1;
                dec_p0.alu_src_b  = 1'b1;
                use_rs1           = 1'b1;
            end
            OP_LUI: begin
                dec_p0.reg_write = 1'b1;
                dec_p0.alu_src_b = 1'b1;
                dec_p0.alu_ctrl  = 4'hA;
                imm_src          = 3'b100;
            end
            OP_AUIPC: begin
                dec_p0.reg_write = 1'b1;
                dec_p0.alu_src_a = 1'b1;
                dec_p0.alu_src_b = 1'b1;
                imm_src          = 3'b100;
            end
            default: begin
                dec_p0.valid = 1'b0;
                illegal      = 1'b1;
            end
        endcase
        // Only instructions that write rd carry a destination; x0 stays 0 anyway
        dec_p0.rd = dec_p0.reg_write ? rd_f : 5'd0;
    end

    // Load-use hazard: the load in E has not produced data the D instruction reads
    always_comb begin
        hazard = bus.ValidD && ctrl_p1.valid && (ctrl_p1.result_src == 2'b01) &&
                 (ctrl_p1.rd != 5'd0) &&
                 (((rs1 == ctrl_p1.rd) && use_rs1) || ((rs2 == ctrl_p1.rd) && use_rs2));
    end

    // ---- D -> E boundary: ID/EX control register and illegal counter ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_p1    <= '0;
            illegal_p1 <= 1'b0;
            ill_cnt    <= '0;
        end else begin
            ctrl_p1    <= '0;
            illegal_p1 <= 1'b0;
            if (bus.FlushE || hazard || !bus.ValidD) begin
                // bubble; a flushed illegal is simply dropped
            end else if (illegal) begin
                illegal_p1 <= 1'b1;
                if (ill_cnt != {CNT_W{1'b1}})
                    ill_cnt <= ill_cnt + 1'b1;
            end else begin
                ctrl_p1 <= dec_p0;
            end
        end
    end

    assign bus.ImmSrcD     = imm_src;
    assign bus.StallF      = hazard;
    assign bus.StallD      = hazard;
    assign bus.ValidE      = ctrl_p1.valid;
    assign bus.RegWriteE   = ctrl_p1.reg_write;
    assign bus.ResultSrcE  = ctrl_p1.result_src;
    assign bus.MemWriteE   = ctrl_p1.mem_write;
    assign bus.BranchE     = ctrl_p1.branch;
    assign bus.JumpE       = ctrl_p1.jump;
    assign bus.JalrE       = ctrl_p1.jalr;
    assign bus.ALUSrcAE    = ctrl_p1.alu_src_a;
    assign bus.ALUSrcBE    = ctrl_p1.alu_src_b;
    assign bus.ALUControlE = ctrl_p1.alu_ctrl;
    assign bus.RdE         = ctrl_p1.rd;
    assign bus.IllegalE    = illegal_p1;
    assign bus.IllegalCnt  = ill_cnt;
endmodule
